// File: rtl/cb_filter_pkg.sv
// Shared types and constants for the counting bloom filter front-end controller.
// Contents:
//   arb_state_e - controller state (RUN, DRAIN, CLEAR, ERROR), 2-bit encoding
//   StatWidth   - width of the statistics counters
//   sat_inc     - increment that sticks at all-ones
package cb_filter_pkg;

    localparam int unsigned StatWidth = 32;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2,
        ERROR = 2'd3
    } arb_state_e;

    // Saturating increment for statistics counters.
    function automatic logic [StatWidth-1:0] sat_inc(input logic [StatWidth-1:0] v);
        return (&v) ? v : v + StatWidth'(1);
    endfunction

endpackage

// File: rtl/cb_arb_rr.sv
// Round-robin arbiter with a combinational one-hot grant.
// The grant goes to the first valid index at or after the pointer, wrapping.
// Ports:
//   clk_i, rst_i  - clock, synchronous active-high reset
//   valid_i       - request vector (already qualified by the caller)
//   hs_i          - a handshake completed on the current grant this cycle
//   ptr_rst_i     - force the pointer back to index 0
//   grant_o       - one-hot grant (zero when nothing is valid)
//   grant_idx_o   - index of the granted requester (0 when no grant)
module cb_arb_rr #(
    parameter  int unsigned NumReq = 4,
    localparam int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NumReq-1:0] valid_i,
    input  logic              hs_i,
    input  logic              ptr_rst_i,
    output logic [NumReq-1:0] grant_o,
    output logic [IdxW-1:0]   grant_idx_o
);

    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] cand;
    logic            found;

    // Search from the pointer upward, wrapping modulo NumReq.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = IdxW'((32'(ptr_q) + i) % NumReq);
            if (!found && valid_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                grant_idx_o   = cand;
            end
        end
    end

    // Pointer moves past the winner only when its transfer completes.
    always_comb begin
        ptr_d = ptr_q;
        if (ptr_rst_i) begin
            ptr_d = '0;
        end else if (hs_i) begin
            ptr_d = (grant_idx_o == IdxW'(NumReq - 1)) ? '0 : grant_idx_o + IdxW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cb_filter_arb.sv
// Sequencing and sharing controller in front of one counting bloom filter.
// Arbitrates NumReq insert and NumReq remove requesters onto the filter's
// increment/decrement ports, blocks inserts while the filter is saturated,
// runs a drain-then-clear sequence and holds a sticky error lockout.
// Optional statistics: define CB_FILTER_ARB_STATS_EN to build the counters;
// otherwise stat_*_o are tied to zero.
// Ports:
//   clk_i, rst_i                 - clock, synchronous active-high reset
//   ins_valid_i/data_i/ready_o   - insert requesters (combinational ready)
//   rem_valid_i/data_i/ready_o   - remove requesters (combinational ready)
//   clear_req_i                  - request drain + clear
//   busy_o, err_o                - in DRAIN/CLEAR, in error lockout
//   incr_*_o, decr_*_o           - filter increment / decrement ports
//   filter_clear_o               - one-cycle filter clear
//   filter_full/empty/error/usage_i - filter status
//   stat_ins_o/rem_o/stall_o     - statistics counters
module cb_filter_arb
    import cb_filter_pkg::*;
#(
    parameter int unsigned NumReq      = 4,
    parameter int unsigned InpWidth    = 32,
    parameter int unsigned HashWidth   = 4,
    parameter int unsigned DrainCycles = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NumReq-1:0]          ins_valid_i,
    input  logic [NumReq*InpWidth-1:0] ins_data_i,
    output logic [NumReq-1:0]          ins_ready_o,
    input  logic [NumReq-1:0]          rem_valid_i,
    input  logic [NumReq*InpWidth-1:0] rem_data_i,
    output logic [NumReq-1:0]          rem_ready_o,
    input  logic                       clear_req_i,
    output logic                       busy_o,
    output logic                       err_o,
    output logic [InpWidth-1:0]        incr_data_o,
    output logic                       incr_valid_o,
    output logic [InpWidth-1:0]        decr_data_o,
    output logic                       decr_valid_o,
    output logic                       filter_clear_o,
    input  logic                       filter_full_i,
    input  logic                       filter_empty_i,
    input  logic                       filter_error_i,
    input  logic [HashWidth-1:0]       filter_usage_i,
    output logic [StatWidth-1:0]       stat_ins_o,
    output logic [StatWidth-1:0]       stat_rem_o,
    output logic [StatWidth-1:0]       stat_stall_o
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned DcW  = (DrainCycles > 1) ? $clog2(DrainCycles) : 1;

    arb_state_e state_q, state_d;
    logic [DcW-1:0] drain_cnt_q, drain_cnt_d;

    logic ins_en_c, rem_en_c, ptr_rst_c;
    logic ins_block_c;
    logic ins_hs_c, rem_hs_c;
    logic [NumReq-1:0] ins_grant_c, rem_grant_c;
    logic [IdxW-1:0]   ins_idx_c, rem_idx_c;

    // Saturated filter: full flag or usage count at all-ones.
    assign ins_block_c = filter_full_i | (&filter_usage_i);

    // Next state, drain counter, grant enables and status outputs.
    always_comb begin
        state_d        = state_q;
        drain_cnt_d    = drain_cnt_q;
        ins_en_c       = 1'b0;
        rem_en_c       = 1'b0;
        ptr_rst_c      = 1'b0;
        busy_o         = 1'b0;
        err_o          = 1'b0;
        filter_clear_o = 1'b0;
        case (state_q)
            RUN: begin
                if (filter_error_i) begin
                    state_d = ERROR;
                end else begin
                    rem_en_c = 1'b1;
                    if (clear_req_i) begin
                        state_d     = DRAIN;
                        drain_cnt_d = '0;
                    end else begin
                        ins_en_c = ~ins_block_c;
                    end
                end
            end
            DRAIN: begin
                busy_o = 1'b1;
                if (filter_error_i) begin
                    state_d = ERROR;
                end else begin
                    rem_en_c    = 1'b1;
                    drain_cnt_d = drain_cnt_q + DcW'(1);
                    if (filter_empty_i || (drain_cnt_q == DcW'(DrainCycles - 1))) begin
                        state_d     = CLEAR;
                        drain_cnt_d = '0;
                    end
                end
            end
            CLEAR: begin
                busy_o         = 1'b1;
                filter_clear_o = 1'b1;
                ptr_rst_c      = 1'b1;
                state_d        = RUN;
            end
            ERROR: begin
                err_o = 1'b1;
                if (clear_req_i) begin
                    state_d = CLEAR;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
        // No grant may leak out while reset is being applied.
        if (rst_i) begin
            ins_en_c = 1'b0;
            rem_en_c = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    cb_arb_rr #(.NumReq(NumReq)) u_ins_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (ins_valid_i & {NumReq{ins_en_c}}),
        .hs_i        (ins_hs_c),
        .ptr_rst_i   (ptr_rst_c),
        .grant_o     (ins_grant_c),
        .grant_idx_o (ins_idx_c)
    );

    cb_arb_rr #(.NumReq(NumReq)) u_rem_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (rem_valid_i & {NumReq{rem_en_c}}),
        .hs_i        (rem_hs_c),
        .ptr_rst_i   (ptr_rst_c),
        .grant_o     (rem_grant_c),
        .grant_idx_o (rem_idx_c)
    );

    // A grant is only issued to a valid requester, so grant == handshake.
    assign ins_hs_c    = |ins_grant_c;
    assign rem_hs_c    = |rem_grant_c;
    assign ins_ready_o = ins_grant_c;
    assign rem_ready_o = rem_grant_c;

    // Forward the granted payloads; zero when idle.
    always_comb begin
        incr_valid_o = ins_hs_c;
        decr_valid_o = rem_hs_c;
        incr_data_o  = '0;
        decr_data_o  = '0;
        if (ins_hs_c) begin
            incr_data_o = ins_data_i[32'(ins_idx_c)*InpWidth +: InpWidth];
        end
        if (rem_hs_c) begin
            decr_data_o = rem_data_i[32'(rem_idx_c)*InpWidth +: InpWidth];
        end
    end

`ifdef CB_FILTER_ARB_STATS_EN
    logic [StatWidth-1:0] stat_ins_q, stat_rem_q, stat_stall_q;
    logic                 stall_c;

    assign stall_c = (state_q == RUN) & (|ins_valid_i) & ~ins_hs_c;

    // Saturating event counters, zeroed whenever the filter is cleared.
    always_ff @(posedge clk_i) begin
        if (rst_i || (state_q == CLEAR)) begin
            stat_ins_q   <= '0;
            stat_rem_q   <= '0;
            stat_stall_q <= '0;
        end else begin
            if (ins_hs_c) stat_ins_q   <= sat_inc(stat_ins_q);
            if (rem_hs_c) stat_rem_q   <= sat_inc(stat_rem_q);
            if (stall_c)  stat_stall_q <= sat_inc(stat_stall_q);
        end
    end

    assign stat_ins_o   = stat_ins_q;
    assign stat_rem_o   = stat_rem_q;
    assign stat_stall_o = stat_stall_q;
`else
    assign stat_ins_o   = '0;
    assign stat_rem_o   = '0;
    assign stat_stall_o = '0;
`endif

endmodule

// File: tb/tb_cb_filter_arb.sv
// Directed self-checking bench for cb_filter_arb (NumReq=4, DrainCycles=8).
module tb_cb_filter_arb;

    localparam int unsigned NumReq = 4;
    localparam int unsigned InpW   = 32;

    logic              clk = 1'b0;
    logic              rst_i;
    logic [NumReq-1:0] ins_valid_i, rem_valid_i;
    logic [NumReq*InpW-1:0] ins_data_i, rem_data_i;
    logic [NumReq-1:0] ins_ready_o, rem_ready_o;
    logic              clear_req_i;
    logic              busy_o, err_o;
    logic [InpW-1:0]   incr_data_o, decr_data_o;
    logic              incr_valid_o, decr_valid_o, filter_clear_o;
    logic              filter_full_i, filter_empty_i, filter_error_i;
    logic [3:0]        filter_usage_i;
    logic [31:0]       stat_ins_o, stat_rem_o, stat_stall_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cb_filter_arb #(
        .NumReq(NumReq), .InpWidth(InpW), .HashWidth(4), .DrainCycles(8)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .ins_valid_i(ins_valid_i), .ins_data_i(ins_data_i), .ins_ready_o(ins_ready_o),
        .rem_valid_i(rem_valid_i), .rem_data_i(rem_data_i), .rem_ready_o(rem_ready_o),
        .clear_req_i(clear_req_i), .busy_o(busy_o), .err_o(err_o),
        .incr_data_o(incr_data_o), .incr_valid_o(incr_valid_o),
        .decr_data_o(decr_data_o), .decr_valid_o(decr_valid_o),
        .filter_clear_o(filter_clear_o),
        .filter_full_i(filter_full_i), .filter_empty_i(filter_empty_i),
        .filter_error_i(filter_error_i), .filter_usage_i(filter_usage_i),
        .stat_ins_o(stat_ins_o), .stat_rem_o(stat_rem_o), .stat_stall_o(stat_stall_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #2;
    endtask

    initial begin
        for (int i = 0; i < NumReq; i++) begin
            ins_data_i[i*InpW +: InpW] = 32'hA000_0000 + 32'(i);
            rem_data_i[i*InpW +: InpW] = 32'hB000_0000 + 32'(i);
        end
        rst_i = 1'b1;
        ins_valid_i = 4'hF; rem_valid_i = 4'hF;
        clear_req_i = 1'b0;
        filter_full_i = 1'b0; filter_empty_i = 1'b0; filter_error_i = 1'b0;
        filter_usage_i = 4'h0;
        tick(); tick(); settle();

        // Reset: everything quiet even with requests pending.
        check("rst_ins_ready", 32'(ins_ready_o), 32'h0);
        check("rst_rem_ready", 32'(rem_ready_o), 32'h0);
        check("rst_incr_valid", 32'(incr_valid_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_err", 32'(err_o), 32'h0);
        check("rst_fclear", 32'(filter_clear_o), 32'h0);
        check("rst_stat_ins", stat_ins_o, 32'h0);

        // Round robin over all four inserters.
        rem_valid_i = 4'h0;
        rst_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            settle();
            check("rr_ready", 32'(ins_ready_o), 32'(1) << (k % 4));
            check("rr_incr_valid", 32'(incr_valid_o), 32'h1);
            check("rr_incr_data", incr_data_o, 32'hA000_0000 + 32'(k % 4));
            tick();
        end

        // Concurrent insert and remove.
        ins_valid_i = 4'b0100; rem_valid_i = 4'b0010;
        settle();
        check("cc_ins_ready", 32'(ins_ready_o), 32'h4);
        check("cc_rem_ready", 32'(rem_ready_o), 32'h2);
        check("cc_incr_valid", 32'(incr_valid_o), 32'h1);
        check("cc_decr_valid", 32'(decr_valid_o), 32'h1);
        check("cc_incr_data", incr_data_o, 32'hA000_0002);
        check("cc_decr_data", decr_data_o, 32'hB000_0001);
        tick();

        // Saturated filter: usage all-ones, then full flag.
        ins_valid_i = 4'b0001; rem_valid_i = 4'b0001; filter_usage_i = 4'hF;
        settle();
        check("full_usage_ready", 32'(ins_ready_o), 32'h0);
        check("full_incr_valid", 32'(incr_valid_o), 32'h0);
        check("full_incr_data", incr_data_o, 32'h0);
        check("full_rem_ready", 32'(rem_ready_o), 32'h1);
        check("full_decr_data", decr_data_o, 32'hB000_0000);
        tick();
        filter_usage_i = 4'h0; filter_full_i = 1'b1;
        settle();
        check("full_flag_ready", 32'(ins_ready_o), 32'h0);
        check("full_flag_rem", 32'(rem_ready_o), 32'h1);
        tick();
        filter_full_i = 1'b0; rem_valid_i = 4'h0;
        settle();
        check("unfull_ready", 32'(ins_ready_o), 32'h1);
        tick();
`ifdef CB_FILTER_ARB_STATS_EN
        check("stat_ins_pre", stat_ins_o, 32'd10);
        check("stat_rem_pre", stat_rem_o, 32'd3);
        check("stat_stall_pre", stat_stall_o, 32'd2);
`else
        check("stat_ins_off", stat_ins_o, 32'h0);
        check("stat_stall_off", stat_stall_o, 32'h0);
`endif

        // Clear sequence: request cycle blocks inserts but serves removes.
        clear_req_i = 1'b1; ins_valid_i = 4'b0001; rem_valid_i = 4'b0001;
        settle();
        check("clr_req_ins", 32'(ins_ready_o), 32'h0);
        check("clr_req_rem", 32'(rem_ready_o), 32'h1);
        check("clr_req_busy", 32'(busy_o), 32'h0);
        tick();
        rem_valid_i = 4'b0010;
        settle();
        check("drain0_busy", 32'(busy_o), 32'h1);
        check("drain0_ins", 32'(ins_ready_o), 32'h0);
        check("drain0_rem", 32'(rem_ready_o), 32'h2);
        check("drain0_fclear", 32'(filter_clear_o), 32'h0);
        tick();
        clear_req_i = 1'b0; ins_valid_i = 4'h0; rem_valid_i = 4'h0;
        settle();
        check("drain1_busy", 32'(busy_o), 32'h1);
        tick();
        filter_empty_i = 1'b1;
        settle();
        check("drain2_busy", 32'(busy_o), 32'h1);
        check("drain2_fclear", 32'(filter_clear_o), 32'h0);
        tick();
        filter_empty_i = 1'b0; ins_valid_i = 4'hF; rem_valid_i = 4'hF;
        settle();
        check("clear_busy", 32'(busy_o), 32'h1);
        check("clear_fclear", 32'(filter_clear_o), 32'h1);
        check("clear_ins", 32'(ins_ready_o), 32'h0);
        check("clear_rem", 32'(rem_ready_o), 32'h0);
        tick();
        settle();
        check("post_busy", 32'(busy_o), 32'h0);
        check("post_fclear", 32'(filter_clear_o), 32'h0);
        check("post_ins_ptr", 32'(ins_ready_o), 32'h1);
        check("post_rem_ptr", 32'(rem_ready_o), 32'h1);
        check("post_stat_ins", stat_ins_o, 32'h0);
        check("post_stat_stall", stat_stall_o, 32'h0);
        tick();
        ins_valid_i = 4'h0; rem_valid_i = 4'h0;

        // Drain timeout: exactly eight DRAIN cycles, then CLEAR.
        clear_req_i = 1'b1;
        tick();
        clear_req_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            settle();
            check("to_busy", 32'(busy_o), 32'h1);
            check("to_fclear", 32'(filter_clear_o), 32'h0);
            tick();
        end
        settle();
        check("to_clear", 32'(filter_clear_o), 32'h1);
        tick();
        settle();
        check("to_run_busy", 32'(busy_o), 32'h0);

        // Error in RUN: no grants that cycle, lockout next.
        filter_error_i = 1'b1; ins_valid_i = 4'hF; rem_valid_i = 4'hF;
        settle();
        check("err_run_ins", 32'(ins_ready_o), 32'h0);
        check("err_run_rem", 32'(rem_ready_o), 32'h0);
        check("err_run_err", 32'(err_o), 32'h0);
        tick();
        settle();
        check("err_lock_err", 32'(err_o), 32'h1);
        check("err_lock_ins", 32'(ins_ready_o), 32'h0);
        check("err_lock_rem", 32'(rem_ready_o), 32'h0);
        check("err_lock_busy", 32'(busy_o), 32'h0);
        filter_error_i = 1'b0;
        tick();
        settle();
        check("err_sticky", 32'(err_o), 32'h1);
        clear_req_i = 1'b1;
        tick();
        clear_req_i = 1'b0;
        settle();
        check("err_clr_err", 32'(err_o), 32'h0);
        check("err_clr_fclear", 32'(filter_clear_o), 32'h1);
        tick();
        settle();
        check("err_run_fclear", 32'(filter_clear_o), 32'h0);
        check("err_run_grant", 32'(ins_ready_o), 32'h1);
        ins_valid_i = 4'h0; rem_valid_i = 4'h0;
        tick();

        // Error wins over empty while draining.
        clear_req_i = 1'b1;
        tick();
        clear_req_i = 1'b0; filter_error_i = 1'b1; filter_empty_i = 1'b1;
        tick();
        filter_error_i = 1'b0; filter_empty_i = 1'b0;
        settle();
        check("derr_err", 32'(err_o), 32'h1);
        check("derr_fclear", 32'(filter_clear_o), 32'h0);
        clear_req_i = 1'b1;
        tick();
        clear_req_i = 1'b0;
        tick();

        // Reset in the middle of DRAIN.
        clear_req_i = 1'b1;
        tick();
        clear_req_i = 1'b0;
        settle();
        check("mid_busy", 32'(busy_o), 32'h1);
        rst_i = 1'b1; ins_valid_i = 4'hF; rem_valid_i = 4'hF;
        tick();
        settle();
        check("mid_rst_busy", 32'(busy_o), 32'h0);
        check("mid_rst_fclear", 32'(filter_clear_o), 32'h0);
        check("mid_rst_ins", 32'(ins_ready_o), 32'h0);
        check("mid_rst_decr", 32'(decr_valid_o), 32'h0);
        rst_i = 1'b0; ins_valid_i = 4'h0; rem_valid_i = 4'h0;
        tick();
        settle();
        check("mid_run_busy", 32'(busy_o), 32'h0);
        check("mid_run_err", 32'(err_o), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cb_filter_arb.md
Name: cb_filter_arb

Overview:
- Sequencing and sharing controller in front of one counting bloom filter instance.
- Arbitrates NumReq insert requesters and NumReq remove requesters onto the filter's single increment and single decrement port, using valid/ready handshakes.
- Blocks inserts while the filter is saturated.
- Runs a drain-then-clear sequence and holds the filter in a sticky error lockout until software clears it.

Parameters:
- NumReq, 4, number of requester ports per direction (≥1).
- InpWidth, 32, data width; must match the filter.
- HashWidth, 4, width of the filter usage count.
- DrainCycles, 64, maximum cycles in DRAIN before a forced clear (≥1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- ins_valid_i  in  NumReq  insert request per requester
- ins_data_i  in  NumReq x InpWidth  insert data
- ins_ready_o  out  NumReq  insert accepted
- rem_valid_i  in  NumReq  remove request per requester
- rem_data_i  in  NumReq x InpWidth  remove data
- rem_ready_o  out  NumReq  remove accepted
- clear_req_i  in  1  request drain+clear (pulse or level)
- busy_o  out  1  controller in DRAIN or CLEAR
- err_o  out  1  sticky filter error lockout
- incr_data_o  out  InpWidth  to filter increment data
- incr_valid_o  out  1  to filter increment valid
- decr_data_o  out  InpWidth  to filter decrement data
- decr_valid_o  out  1  to filter decrement valid
- filter_clear_o  out  1  to filter clear
- filter_full_i  in  1  from filter
- filter_empty_i  in  1  from filter
- filter_error_i  in  1  from filter
- filter_usage_i  in  HashWidth  from filter
- stat_ins_o  out  32  accepted inserts (feature)
- stat_rem_o  out  32  accepted removes (feature)
- stat_stall_o  out  32  insert-stall cycles (feature)

Behaviour:
- Clock and reset: one clock, clk_i; reset is synchronous and active-high, rst_i.
- Reset values:
  - state=RUN; both round-robin pointers=0; drain counter=0.
  - All ready/valid outputs, filter_clear_o, busy_o and err_o = 0.
  - Stat counters = 0.
- Handshake:
  - Zero-latency, combinational grant; a transfer occurs when valid & ready.
  - Requesters hold valid and data stable until ready.
  - At most one ready bit per direction per cycle.
- Arbitration:
  - Independent round-robin per direction. The grant goes to the first valid index at or after the pointer, wrapping.
  - On a handshake the pointer loads (granted index + 1) mod NumReq; otherwise it is held.
- Datapath:
  - incr_valid_o = any insert handshake; incr_data_o = granted data, else 0.
  - Same rule for the decrement port.
  - An insert and a remove in the same cycle are both forwarded; the filter resolves the overlap.
- Insert gating: in RUN, ins_ready_o = 0 when filter_full_i=1 or filter_usage_i = all-ones. This holds even if a remove is granted in the same cycle.
- Remove gating: removes are always grantable in RUN and DRAIN.
- FSM:
  - RUN:
    - filter_error_i=1 → ERROR, with no grants that cycle.
    - Else clear_req_i=1 → DRAIN, with counter=0 and no inserts that cycle.
  - DRAIN:
    - Inserts blocked, removes served, busy_o=1, counter increments.
    - filter_empty_i=1 or counter = DrainCycles-1 → CLEAR.
    - filter_error_i → ERROR (error has priority).
  - CLEAR:
    - filter_clear_o=1 for exactly one cycle; no grants; busy_o=1.
    - → RUN, with both pointers reset to 0.
  - ERROR:
    - err_o=1; no grants; filter_error_i is ignored.
    - clear_req_i → CLEAR; err_o drops when CLEAR is entered.
- Priority: filter_error_i > clear_req_i. clear_req_i asserted while in DRAIN or CLEAR is ignored.
- Reset mid-sequence: returns to RUN immediately. filter_clear_o is not issued; the filter has its own reset.

Optional Feature:
- Macro: CB_FILTER_ARB_STATS_EN.
- Defined:
  - stat_ins_o and stat_rem_o count handshakes.
  - stat_stall_o counts cycles in RUN with any ins_valid_i=1 and all ins_ready_o=0.
  - All three saturate at all-ones and are zeroed in CLEAR.
- Undefined: the stat ports exist but are tied to 0, and no counter flops are generated.

Decomposition:
- cb_filter_pkg:
  - Add arb_state_e (RUN, DRAIN, CLEAR, ERROR), 2-bit encoding.
  - Add constant StatWidth=32.
- One sub-module, cb_arb_rr:
  - Parameterised NumReq.
  - Inputs: valid vector, handshake-done, pointer reset.
  - Outputs: one-hot grant and grant index.
  - Instantiated twice (insert and remove).

Test Plan:
- Round-robin: NumReq=4, all ins_valid_i=1 for 8 cycles, filter not full → grants 0,1,2,3,0,1,2,3; incr_valid_o=1 every cycle, incr_data_o = matching data.
- Concurrent directions: ins_valid_i[2] and rem_valid_i[1] in the same cycle → both ready; incr_valid_o=decr_valid_o=1 in that cycle.
- Full stall: filter_usage_i=4'hF with ins_valid_i=4'b0001 → ins_ready_o=0 and rem still served; with stats enabled, stat_stall_o increments each cycle.
- Clear: clear_req_i pulse, filter_empty_i=1 after 3 cycles → busy_o for 4 cycles, then filter_clear_o high exactly one cycle, back to RUN, pointers=0.
- Drain timeout: DrainCycles=8, filter_empty_i held 0 → CLEAR entered after exactly 8 DRAIN cycles.
- Error: filter_error_i=1 in RUN → next cycle err_o=1 and all ready=0. A later clear_req_i → one filter_clear_o cycle, err_o=0. rst_i mid-DRAIN → RUN with all outputs 0.
